// File: rtl/ad1xx_pkg.sv
// Shared opcode, state and mux-select encodings for the multi-cycle sequencer.
// Imported by the sequencer top, its timeout counter and the bus interface.
package ad1xx_pkg;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_FETCH     = 3'd1,
    S_DECODE    = 3'd2,
    S_EXECUTE   = 3'd3,
    S_MEM       = 3'd4,
    S_WRITEBACK = 3'd5,
    S_HALT      = 3'd6,
    S_FAULT     = 3'd7
  } state_t;

  localparam logic [1:0] PC_PLUS4 = 2'b00;
  localparam logic [1:0] PC_IMM   = 2'b01;
  localparam logic [1:0] PC_ALU   = 2'b10;

  localparam logic [1:0] WB_ALU = 2'b00;
  localparam logic [1:0] WB_MEM = 2'b01;
  localparam logic [1:0] WB_PC4 = 2'b10;
  localparam logic [1:0] WB_IMM = 2'b11;

  function automatic logic is_rv32i(input logic [6:0] op);
    return op inside {OP_LUI, OP_AUIPC, OP_JAL,
                      OP_JALR, OP_BRANCH, OP_LOAD,
                      OP_STORE, OP_IMM, OP_OP,
                      OP_SYSTEM};
  endfunction

endpackage

// File: rtl/cpu_sequencer_if.sv
// Control bundle between the sequencer and the datapath/memory side.
// master = sequencer (drives strobes), slave = datapath (drives status).
interface cpu_sequencer_if;
  import ad1xx_pkg::*;

  logic        run;
  logic [31:0] instr;
  logic        mem_ready;
  logic        branch_taken;
  logic        mem_req;
  logic        mem_we;
  logic        mem_addr_sel;
  logic        ir_we;
  logic        pc_we;
  logic [1:0]  pc_sel;
  logic        reg_we;
  logic [1:0]  wb_sel;
  logic [2:0]  state;
  logic        fault;
  logic        retired;

  modport master (
    input  run, instr, mem_ready, branch_taken,
    output mem_req, mem_we, mem_addr_sel, ir_we,
    output pc_we, pc_sel, reg_we, wb_sel,
    output state, fault, retired
  );

  modport slave (
    output run, instr, mem_ready, branch_taken,
    input  mem_req, mem_we, mem_addr_sel, ir_we,
    input  pc_we, pc_sel, reg_we, wb_sel,
    input  state, fault, retired
  );

endinterface

// File: rtl/seq_timeout.sv
// Memory-wait watchdog: counts stalled cycles, expired at STALL_LIMIT.
// Ports: clk, rst_n (sync, active low), clear, count_en, expired.
module seq_timeout
  import ad1xx_pkg::*;
#(
  parameter int STALL_LIMIT = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic count_en,
  output logic expired
);

  logic [7:0] cnt;

  assign expired = (cnt == 8'(STALL_LIMIT));

  // Saturates at the limit so a long stall never wraps back to zero.
  always_ff @(posedge clk) begin
    if (!rst_n)
      cnt <= '0;
    else if (clear)
      cnt <= '0;
    else if (count_en && !expired)
      cnt <= cnt + 8'd1;
  end

endmodule

// File: rtl/cpu_sequencer.sv
// Multi-cycle RV32I control sequencer: FETCH/DECODE/EXECUTE/MEM/WB.
// In: clk, rst_n, run, instr, mem_ready, branch_taken. Out: strobes, state, fault, retired.
module cpu_sequencer
  import ad1xx_pkg::*;
#(
  parameter int STALL_LIMIT = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        run,
  input  logic [31:0] instr,
  input  logic        mem_ready,
  input  logic        branch_taken,
  output logic        mem_req,
  output logic        mem_we,
  output logic        mem_addr_sel,
  output logic        ir_we,
  output logic        pc_we,
  output logic [1:0]  pc_sel,
  output logic        reg_we,
  output logic [1:0]  wb_sel,
  output logic [2:0]  state,
  output logic        fault,
  output logic        retired
);

  state_t     cur, nxt;
  logic [6:0] op;
  logic       req_c, we_c, asel_c, irwe_c;
  logic       pcwe_c, regwe_c, ret_c;
  logic [1:0] pcsel_c, wbsel_c;
  logic       expired, waiting, tmo_clear;
  logic       instr_unused;

  assign op           = instr[6:0];
  assign instr_unused = ^instr[31:7];

  assign waiting   = (cur == S_FETCH || cur == S_MEM)
                   && !mem_ready;
  assign tmo_clear = mem_ready || (nxt != cur);

  seq_timeout #(
    .STALL_LIMIT(STALL_LIMIT)
  ) u_timeout (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (tmo_clear),
    .count_en(waiting),
    .expired (expired)
  );

  always_ff @(posedge clk) begin
    if (!rst_n)
      cur <= S_IDLE;
    else
      cur <= nxt;
  end

  always_comb begin
    nxt     = cur;
    req_c   = 1'b0;
    we_c    = 1'b0;
    asel_c  = 1'b0;
    irwe_c  = 1'b0;
    pcwe_c  = 1'b0;
    regwe_c = 1'b0;
    ret_c   = 1'b0;
    pcsel_c = PC_PLUS4;
    wbsel_c = WB_ALU;
    case (cur)
      S_IDLE: begin
        if (run) nxt = S_FETCH;
      end
      S_FETCH: begin
        req_c = 1'b1;
        if (expired) begin
          nxt = S_FAULT;
        end else if (mem_ready) begin
          irwe_c = 1'b1;
          nxt    = S_DECODE;
        end
      end
      S_DECODE: begin
        if (op == OP_SYSTEM)
          nxt = S_HALT;
        else if (!is_rv32i(op))
          nxt = S_FAULT;
        else
          nxt = S_EXECUTE;
      end
      S_EXECUTE: begin
        unique case (1'b1)
          op == OP_LOAD,
          op == OP_STORE: nxt = S_MEM;
          op == OP_BRANCH: begin
            pcwe_c  = 1'b1;
            pcsel_c = branch_taken ? PC_IMM : PC_PLUS4;
            ret_c   = 1'b1;
            nxt     = run ? S_FETCH : S_IDLE;
          end
          default: nxt = S_WRITEBACK;
        endcase
      end
      S_MEM: begin
        req_c  = 1'b1;
        asel_c = 1'b1;
        we_c   = (op == OP_STORE);
        if (expired) begin
          nxt = S_FAULT;
        end else if (mem_ready) begin
          if (op == OP_STORE) begin
            pcwe_c = 1'b1;
            ret_c  = 1'b1;
            nxt    = run ? S_FETCH : S_IDLE;
          end else begin
            nxt = S_WRITEBACK;
          end
        end
      end
      S_WRITEBACK: begin
        regwe_c = 1'b1;
        pcwe_c  = 1'b1;
        ret_c   = 1'b1;
        unique case (1'b1)
          op == OP_LOAD: wbsel_c = WB_MEM;
          op == OP_JAL: begin
            wbsel_c = WB_PC4;
            pcsel_c = PC_IMM;
          end
          op == OP_JALR: begin
            wbsel_c = WB_PC4;
            pcsel_c = PC_ALU;
          end
          op == OP_LUI: wbsel_c = WB_IMM;
          default: wbsel_c = WB_ALU;
        endcase
        nxt = run ? S_FETCH : S_IDLE;
      end
      S_HALT:  nxt = S_HALT;
      S_FAULT: nxt = S_FAULT;
    endcase
  end

  // Strobes are forced low while reset is held, independent of state.
  assign mem_req      = rst_n & req_c;
  assign mem_we       = rst_n & we_c;
  assign mem_addr_sel = rst_n & asel_c;
  assign ir_we        = rst_n & irwe_c;
  assign pc_we        = rst_n & pcwe_c;
  assign reg_we       = rst_n & regwe_c;
  assign retired      = rst_n & ret_c;
  assign pc_sel       = rst_n ? pcsel_c : 2'b00;
  assign wb_sel       = rst_n ? wbsel_c : 2'b00;

  assign state = cur;
  assign fault = (cur == S_FAULT);

endmodule

// File: tb/tb_cpu_sequencer.sv
// Randomized self-checking bench for cpu_sequencer.
// Builds expected per-cycle traces from instruction class and wait counts.
module tb_cpu_sequencer;

  localparam logic [6:0] LUI = 7'b0110111;
  localparam logic [6:0] AUI = 7'b0010111;
  localparam logic [6:0] JAL = 7'b1101111;
  localparam logic [6:0] JLR = 7'b1100111;
  localparam logic [6:0] BR  = 7'b1100011;
  localparam logic [6:0] LD  = 7'b0000011;
  localparam logic [6:0] ST  = 7'b0100011;
  localparam logic [6:0] OPI = 7'b0010011;
  localparam logic [6:0] OPR = 7'b0110011;
  localparam logic [6:0] SYS = 7'b1110011;

  typedef struct packed {
    logic        run;
    logic        mr;
    logic        bt;
    logic [31:0] ins;
    logic [14:0] exp;
  } row_t;

  logic clk = 1'b0;
  logic rst_n;

  cpu_sequencer_if bus ();

  cpu_sequencer #(.STALL_LIMIT(15)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .run         (bus.run),
    .instr       (bus.instr),
    .mem_ready   (bus.mem_ready),
    .branch_taken(bus.branch_taken),
    .mem_req     (bus.mem_req),
    .mem_we      (bus.mem_we),
    .mem_addr_sel(bus.mem_addr_sel),
    .ir_we       (bus.ir_we),
    .pc_we       (bus.pc_we),
    .pc_sel      (bus.pc_sel),
    .reg_we      (bus.reg_we),
    .wb_sel      (bus.wb_sel),
    .state       (bus.state),
    .fault       (bus.fault),
    .retired     (bus.retired)
  );

  always #5 clk = ~clk;

  int   n_cmp = 0;
  int   n_bad = 0;
  row_t q[$];
  string tq[$];
  logic at_idle = 1'b1;
  logic [2:0] last_st = 3'd0;
  logic [6:0] ops [9] = '{LUI, AUI, JAL, JLR, BR,
                          LD, ST, OPI, OPR};

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h",
               tag, got, exp);
    end
  endtask

  function automatic logic rb();
    return 1'($urandom);
  endfunction

  function automatic logic legal(input logic [6:0] op);
    return op inside {LUI, AUI, JAL, JLR, BR,
                      LD, ST, OPI, OPR, SYS};
  endfunction

  // {state, req, we, asel, ir_we, pc_we, pc_sel, reg_we, wb_sel, fault, retired}
  function automatic logic [14:0] ev(
    input logic [2:0] st, input logic rq,
    input logic we, input logic as,
    input logic ir, input logic pw,
    input logic [1:0] ps, input logic rw,
    input logic [1:0] ws, input logic rt);
    return {st, rq, we, as, ir, pw, ps, rw, ws,
            (st == 3'd7), rt};
  endfunction

  function automatic logic [14:0] quiet(input logic [2:0] st);
    return ev(st, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
              2'b00, 1'b0, 2'b00, 1'b0);
  endfunction

  function automatic logic [14:0] obs();
    return {bus.state, bus.mem_req, bus.mem_we,
            bus.mem_addr_sel, bus.ir_we, bus.pc_we,
            bus.pc_sel, bus.reg_we, bus.wb_sel,
            bus.fault, bus.retired};
  endfunction

  task automatic push(input string t, input logic ru,
                      input logic mr,
                      input logic [31:0] ins,
                      input logic bt,
                      input logic [14:0] e);
    row_t r;
    r.run = ru;
    r.mr  = mr;
    r.bt  = bt;
    r.ins = ins;
    r.exp = e;
    q.push_back(r);
    tq.push_back(t);
  endtask

  task automatic idle_tail(input logic lr);
    if (!lr) begin
      at_idle = 1'b1;
      repeat ($urandom_range(0, 2))
        push("idle", 1'b0, rb(), $urandom, rb(), quiet(3'd0));
    end
  endtask

  // Expected trace of one instruction from (re)entry to retire.
  task automatic gen(input logic [31:0] ins,
                     input int fw, input int mw,
                     input int btm, input logic lr);
    logic [6:0] op;
    logic st, bt;
    logic [1:0] wbs, pcs;
    op = ins[6:0];
    if (at_idle)
      push("idle_go", 1'b1, rb(), $urandom, rb(), quiet(3'd0));
    at_idle = 1'b0;
    for (int i = 0; i < fw; i++)
      push("fetch_wait", rb(), 1'b0, $urandom, rb(),
           ev(3'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0,
              2'b00, 1'b0, 2'b00, 1'b0));
    push("fetch_done", rb(), 1'b1, $urandom, rb(),
         ev(3'd1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0,
            2'b00, 1'b0, 2'b00, 1'b0));
    push("decode", rb(), rb(), ins, rb(), quiet(3'd2));
    if (op == SYS) begin
      repeat (4) push("halt", rb(), rb(), ins, rb(), quiet(3'd6));
      return;
    end
    if (!legal(op)) begin
      repeat (4) push("fault", rb(), rb(), ins, rb(), quiet(3'd7));
      return;
    end
    if (op == BR) begin
      bt = (btm < 0) ? rb() : 1'(btm);
      push("br_exec", lr, rb(), ins, bt,
           ev(3'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1,
              {1'b0, bt}, 1'b0, 2'b00, 1'b1));
      idle_tail(lr);
      return;
    end
    push("exec", rb(), rb(), ins, rb(), quiet(3'd3));
    if (op == LD || op == ST) begin
      st = (op == ST);
      for (int i = 0; i < mw; i++)
        push("mem_wait", rb(), 1'b0, ins, rb(),
             ev(3'd4, 1'b1, st, 1'b1, 1'b0, 1'b0,
                2'b00, 1'b0, 2'b00, 1'b0));
      if (st) begin
        push("st_done", lr, 1'b1, ins, rb(),
             ev(3'd4, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1,
                2'b00, 1'b0, 2'b00, 1'b1));
        idle_tail(lr);
        return;
      end
      push("ld_done", rb(), 1'b1, ins, rb(),
           ev(3'd4, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0,
              2'b00, 1'b0, 2'b00, 1'b0));
    end
    wbs = 2'b00;
    pcs = 2'b00;
    if (op == LD) wbs = 2'b01;
    if (op == JAL) begin wbs = 2'b10; pcs = 2'b01; end
    if (op == JLR) begin wbs = 2'b10; pcs = 2'b10; end
    if (op == LUI) wbs = 2'b11;
    push("wb", lr, rb(), ins, rb(),
         ev(3'd5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1,
            pcs, 1'b1, wbs, 1'b1));
    idle_tail(lr);
  endtask

  task automatic play(input int n);
    int   k;
    row_t r;
    string t;
    k = 0;
    while (q.size() > 0 && (n < 0 || k < n)) begin
      r = q.pop_front();
      t = tq.pop_front();
      @(negedge clk);
      rst_n            = 1'b1;
      bus.run          = r.run;
      bus.mem_ready    = r.mr;
      bus.instr        = r.ins;
      bus.branch_taken = r.bt;
      #1;
      chk(t, 32'(obs()), 32'(r.exp));
      last_st = r.exp[14:12];
      k++;
    end
  endtask

  task automatic reset_now();
    logic [2:0] s;
    s = (q.size() > 0) ? q[0].exp[14:12] : last_st;
    q.delete();
    tq.delete();
    @(negedge clk);
    rst_n            = 1'b0;
    bus.run          = rb();
    bus.mem_ready    = rb();
    bus.instr        = $urandom;
    bus.branch_taken = rb();
    #1;
    chk("rst_low", 32'(obs()), 32'(quiet(s)));
    @(negedge clk);
    bus.run = 1'b0;
    #1;
    chk("rst_state", 32'(obs()), 32'(quiet(3'd0)));
    at_idle = 1'b1;
    last_st = 3'd0;
  endtask

  initial begin
    logic [31:0] r;
    logic [6:0]  op;
    int          fw, mw;
    rst_n            = 1'b0;
    bus.run          = 1'b1;
    bus.mem_ready    = 1'b1;
    bus.instr        = 32'h0;
    bus.branch_taken = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("reset_state", 32'(obs()), 32'(quiet(3'd0)));

    gen(32'h00500093, 0, 0, -1, 1'b1);
    gen(32'h0000a103, 0, 3, -1, 1'b1);
    gen(32'h00208463, 0, 0, 1, 1'b1);
    gen(32'h00208463, 1, 0, 0, 1'b1);
    gen(32'h0000a103, 2, 3, -1, 1'b0);
    gen(32'h00500093, 14, 0, -1, 1'b1);
    play(-1);

    for (int i = 0; i < 150; i++) begin
      r  = $urandom;
      op = ops[$urandom_range(0, 8)];
      fw = ($urandom_range(0, 9) == 0) ? 14 : $urandom_range(0, 3);
      mw = ($urandom_range(0, 9) == 0) ? 14 : $urandom_range(0, 3);
      gen({r[31:7], op}, fw, mw, -1,
          1'($urandom_range(0, 3) != 0));
      play(-1);
    end

    gen(32'h00100073, 0, 0, -1, 1'b1);
    play(-1);
    reset_now();

    gen(32'hffffffff, 1, 0, -1, 1'b1);
    play(-1);
    reset_now();

    for (int i = 0; i < 3; i++) begin
      r = $urandom;
      while (legal(r[6:0])) r = $urandom;
      gen(r, 0, 0, -1, 1'b1);
      play(-1);
      reset_now();
    end

    push("idle_go", 1'b1, 1'b0, $urandom, rb(), quiet(3'd0));
    repeat (16)
      push("stall", rb(), 1'b0, $urandom, rb(),
           ev(3'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0,
              2'b00, 1'b0, 2'b00, 1'b0));
    repeat (3)
      push("stall_fault", rb(), rb(), $urandom, rb(), quiet(3'd7));
    play(-1);
    reset_now();

    gen(32'h0000a103, 0, 3, -1, 1'b1);
    play(5);
    reset_now();
    gen(32'h00500093, 0, 0, -1, 1'b1);
    play(-1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/cpu_sequencer.md
CPU_SEQUENCER -- requirements
Module: cpu_sequencer

Interface
REQ-001 The parameter list SHALL be: STALL_LIMIT, 15, memory-wait cycles tolerated before fault (range 1..255).
REQ-002 The block SHALL have exactly these ports, in this order:
- clk  in  1  sole clock; all state changes on the rising edge.
- rst_n  in  1  synchronous, active-low reset.
- run  in  1  permission to start new instructions.
- instr  in  32  IR contents; valid from DECODE onward.
- mem_ready  in  1  memory handshake completion.
- branch_taken  in  1  ALU compare result.
- mem_req  out  1  memory access request.
- mem_we  out  1  store strobe.
- mem_addr_sel  out  1  0=PC, 1=ALU result.
- ir_we  out  1  IR load.
- pc_we  out  1  PC load.
- pc_sel  out  2  00=PC+4, 01=PC+imm, 10=ALU (JALR).
- reg_we  out  1  regfile write.
- wb_sel  out  2  00=ALU, 01=mem data, 10=PC+4, 11=imm.
- state  out  3  current state code.
- fault  out  1  sticky error flag.
- retired  out  1  one-cycle pulse per completed instruction.

Function
REQ-003 The states SHALL be IDLE=0, FETCH=1, DECODE=2, EXECUTE=3, MEM=4, WRITEBACK=5, HALT=6, FAULT=7.
REQ-004 IDLE SHALL move to FETCH when run=1; with run=0 it SHALL stay in IDLE.
REQ-005 FETCH SHALL assert mem_req=1 and mem_addr_sel=0.
- If mem_ready=1: ir_we=1 that cycle, then DECODE.
- Otherwise: remain in FETCH.
REQ-006 DECODE SHALL decode opcode instr[6:0].
- 1110011 (SYSTEM): to HALT.
- Any opcode outside RV32I {0110111, 0010111, 1101111, 1100111, 1100011, 0000011, 0100011, 0010011, 0110011, 1110011}: to FAULT.
- All others: to EXECUTE.
REQ-007 EXECUTE SHALL route by opcode.
- LOAD/STORE: to MEM.
- BRANCH: pc_we=1, pc_sel=branch_taken?01:00, retired=1, then FETCH.
- All others: to WRITEBACK.
REQ-008 MEM SHALL assert mem_req=1, mem_addr_sel=1 and mem_we=1 only for STORE.
- mem_ready=1 with LOAD: to WRITEBACK.
- mem_ready=1 with STORE: pc_we=1, pc_sel=00, retired=1, then FETCH.
- mem_ready=0: remain in MEM.
REQ-009 WRITEBACK SHALL assert reg_we=1, pc_we=1 and retired=1, then go to FETCH. Selects by opcode:
- OP/OP-IMM/AUIPC: wb_sel=00.
- LOAD: wb_sel=01.
- JAL/JALR: wb_sel=10.
- LUI: wb_sel=11.
- pc_sel: JAL=01, JALR=10, others=00.
REQ-010 Every transition marked "then FETCH" SHALL go to IDLE instead when run=0 in that cycle; deasserting run SHALL never abort an instruction in progress.
REQ-011 A wait counter SHALL count consecutive FETCH/MEM cycles with mem_ready=0 and clear on mem_ready=1 or on a state change. When it reaches STALL_LIMIT, the next edge SHALL enter FAULT.
REQ-012 Zero-wait latencies, FETCH entry to retired pulse, SHALL be:
- branch: 3 cycles.
- ALU/LUI/AUIPC/JAL/JALR/STORE: 4 cycles.
- LOAD: 5 cycles.
- Each memory wait cycle adds exactly 1.
REQ-013 HALT and FAULT SHALL be absorbing until reset, with every strobe deasserted; fault=1 exactly while in FAULT. HALT SHALL NOT pulse retired.
REQ-014 Strobe outputs SHALL be combinational functions of state, opcode, mem_ready and branch_taken. The state output SHALL be registered.
REQ-015 mem_req SHALL be held continuously from entry to a FETCH/MEM state until mem_ready=1; it SHALL never drop mid-handshake.
REQ-016 The block SHALL never assert reg_we, pc_we or ir_we in the same cycle as fault=1.

Reset
REQ-017 With rst_n=0 at a rising edge, the block SHALL enter IDLE, clear the wait counter and deassert all outputs (state=0, fault=0), from any state including mid-handshake.
REQ-018 While rst_n=0, all strobes SHALL read 0 regardless of other inputs.

Structure
REQ-019 A shared package ad1xx_pkg SHALL hold:
- RV32I opcode constants.
- The state enum.
- pc_sel and wb_sel encodings.
REQ-020 The wait counter SHALL be a separate sub-module seq_timeout with ports clk, rst_n, clear, count_en and expired, parameterised by STALL_LIMIT.

Verification
REQ-021 addi x1,x0,5 (0x00500093), mem_ready=1, run=1 -> WRITEBACK with reg_we=1, wb_sel=00, pc_sel=00; retired on cycle 4.
REQ-022 lw x2,0(x1) (0x0000a103), mem_ready low 3 cycles in MEM -> mem_req held 4 cycles; WRITEBACK wb_sel=01; retired on cycle 8.
REQ-023 beq x1,x2 (0x00208463), branch_taken=1 -> EXECUTE pc_we=1, pc_sel=01, reg_we=0; retired on cycle 3.
REQ-024 Illegal opcode (0xffffffff) -> DECODE to FAULT; state=7, fault=1 held until rst_n=0, then state=0 next edge.
REQ-025 mem_ready=0 for 15 cycles in FETCH -> FAULT on the 16th edge. Separately, ebreak (0x00100073) -> HALT with no retired pulse and no further mem_req.
REQ-026 run dropped during a LOAD's MEM wait -> load completes with reg_we=1, then IDLE; no new FETCH until run=1.
